// File: rtl/match_pkg.sv
// Shared types and constants for the single-level order matching engine.
// Holds the control FSM state encoding and the order side encoding.
// Optional feature macro used by the top level: TRADE_COUNT_EN.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

endpackage

// File: rtl/book_slot.sv
// One resting order: price, quantity and a valid flag.
// Load takes effect on the next clock edge; decrement likewise, with no backpressure.
// Load and decrement are never requested in the same cycle by the engine FSM.
module book_slot #(
  parameter int PW = 8,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic [PW-1:0] i_price,
  input  logic [QW-1:0] i_qty,
  input  logic          i_dec,
  input  logic [QW-1:0] i_dec_qty,
  output logic          o_valid,
  output logic [PW-1:0] o_price,
  output logic [QW-1:0] o_qty
);

  logic          r_valid;
  logic [PW-1:0] r_price;
  logic [QW-1:0] r_qty;

  // Load a new order or consume a fill; a slot filled down to zero goes empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_price <= '0;
      r_qty   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_price <= i_price;
      r_qty   <= i_qty;
    end else if (i_dec) begin
      r_qty <= r_qty - i_dec_qty;
      if (r_qty == i_dec_qty) r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_price = r_price;
  assign o_qty   = r_qty;

endmodule

// File: rtl/order_match_engine.sv
// Single-level order book (best bid / best ask) that emits a match when bid >= ask.
// Latency: order accepted in cycle N, crossing check in N+1, match_valid in N+2.
// Backpressure: stalls in EMIT with stable outputs while match_ready is low.
// Optional feature: TRADE_COUNT_EN adds a saturating trade_count output.
module order_match_engine
  import match_pkg::*;
#(
  parameter int PW = 8,
  parameter int QW = 8
`ifdef TRADE_COUNT_EN
  , parameter int CW = 16
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          order_valid,
  output logic          order_ready,
  input  logic          order_side,
  input  logic [PW-1:0] order_price,
  input  logic [QW-1:0] order_qty,
  output logic          match_valid,
  input  logic          match_ready,
  output logic          match_signal,
  output logic [PW-1:0] buy_price,
  output logic [PW-1:0] sell_price,
  output logic [QW-1:0] match_qty,
  output logic          bid_valid,
  output logic          ask_valid
`ifdef TRADE_COUNT_EN
  , output logic [CW-1:0] trade_count
`endif
);

  state_t        r_state;
  logic          r_order_ready;
  logic          r_match_valid;
  logic [PW-1:0] r_buy_price;
  logic [PW-1:0] r_sell_price;
  logic [QW-1:0] r_match_qty;

  logic          w_accept;
  logic          w_keep;
  logic          w_load_bid;
  logic          w_load_ask;
  logic          w_fill;
  logic          w_cross;
  logic          w_bid_valid;
  logic          w_ask_valid;
  logic [PW-1:0] w_bid_price;
  logic [PW-1:0] w_ask_price;
  logic [QW-1:0] w_bid_qty;
  logic [QW-1:0] w_ask_qty;
  logic [QW-1:0] w_min_qty;

  // A zero-quantity order is handshaken but never touches the book.
  assign w_accept   = order_valid && r_order_ready;
  assign w_keep     = w_accept && (order_qty != '0);
  assign w_load_bid = w_keep && (order_side == SIDE_BUY);
  assign w_load_ask = w_keep && (order_side == SIDE_SELL);
  assign w_fill     = r_match_valid && match_ready;
  assign w_cross    = w_bid_valid && w_ask_valid && (w_bid_price >= w_ask_price);
  assign w_min_qty  = (w_bid_qty < w_ask_qty) ? w_bid_qty : w_ask_qty;

  book_slot #(.PW(PW), .QW(QW)) u_bid (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load_bid),
    .i_price   (order_price),
    .i_qty     (order_qty),
    .i_dec     (w_fill),
    .i_dec_qty (r_match_qty),
    .o_valid   (w_bid_valid),
    .o_price   (w_bid_price),
    .o_qty     (w_bid_qty)
  );

  book_slot #(.PW(PW), .QW(QW)) u_ask (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load_ask),
    .i_price   (order_price),
    .i_qty     (order_qty),
    .i_dec     (w_fill),
    .i_dec_qty (r_match_qty),
    .o_valid   (w_ask_valid),
    .o_price   (w_ask_price),
    .o_qty     (w_ask_qty)
  );

  // Control FSM: accept in IDLE, test for a cross in CHECK, hold the match in EMIT.
  // order_ready and match_valid are registered alongside the state; ready is low
  // during reset and rises on the first clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_order_ready <= 1'b0;
      r_match_valid <= 1'b0;
      r_buy_price   <= '0;
      r_sell_price  <= '0;
      r_match_qty   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_order_ready <= 1'b1;
          if (w_keep) begin
            r_state       <= CHECK;
            r_order_ready <= 1'b0;
          end
        end
        CHECK: begin
          if (w_cross) begin
            r_state       <= EMIT;
            r_match_valid <= 1'b1;
            r_buy_price   <= w_bid_price;
            r_sell_price  <= w_ask_price;
            r_match_qty   <= w_min_qty;
          end else begin
            r_state       <= IDLE;
            r_order_ready <= 1'b1;
          end
        end
        EMIT: begin
          if (match_ready) begin
            r_state       <= IDLE;
            r_match_valid <= 1'b0;
            r_order_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_match_valid <= 1'b0;
          r_order_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRADE_COUNT_EN
  logic [CW-1:0] r_trade_count;

  // Count completed match handshakes, sticking at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trade_count <= '0;
    end else if (w_fill && (r_trade_count != {CW{1'b1}})) begin
      r_trade_count <= r_trade_count + 1'b1;
    end
  end

  assign trade_count = r_trade_count;
`endif

  assign order_ready  = r_order_ready;
  assign match_valid  = r_match_valid;
  assign match_signal = w_fill;
  assign buy_price    = r_buy_price;
  assign sell_price   = r_sell_price;
  assign match_qty    = r_match_qty;
  assign bid_valid    = w_bid_valid;
  assign ask_valid    = w_ask_valid;

endmodule

// File: tb/tb_order_match_engine.sv
// Self-checking bench for order_match_engine: scoreboarded matches, latency,
// backpressure, reset and zero-quantity orders; trade counter when TRADE_COUNT_EN.
module tb_order_match_engine;

`ifdef TRADE_COUNT_EN
  localparam int CW = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       order_valid = 1'b0;
  logic       order_ready;
  logic       order_side = 1'b0;
  logic [7:0] order_price = '0;
  logic [7:0] order_qty = '0;
  logic       match_valid;
  logic       match_ready = 1'b0;
  logic       match_signal;
  logic [7:0] buy_price;
  logic [7:0] sell_price;
  logic [7:0] match_qty;
  logic       bid_valid;
  logic       ask_valid;
`ifdef TRADE_COUNT_EN
  logic [CW-1:0] trade_count;
`endif

  order_match_engine #(
    .PW(8), .QW(8)
`ifdef TRADE_COUNT_EN
    , .CW(CW)
`endif
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .order_valid  (order_valid),
    .order_ready  (order_ready),
    .order_side   (order_side),
    .order_price  (order_price),
    .order_qty    (order_qty),
    .match_valid  (match_valid),
    .match_ready  (match_ready),
    .match_signal (match_signal),
    .buy_price    (buy_price),
    .sell_price   (sell_price),
    .match_qty    (match_qty),
    .bid_valid    (bid_valid),
    .ask_valid    (ask_valid)
`ifdef TRADE_COUNT_EN
    , .trade_count (trade_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] bp;
    logic [7:0] sp;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulse_cnt = 0;

  // Reference book used to predict matches when orders are driven.
  logic       m_bid_v, m_ask_v;
  logic [7:0] m_bid_p, m_ask_p, m_bid_q, m_ask_q;

  always @(posedge clk) if (reset_n && match_valid && match_ready) pulse_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_bid_v = 0; m_ask_v = 0;
    m_bid_p = 0; m_ask_p = 0; m_bid_q = 0; m_ask_q = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; order_valid = 1'b0; match_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Drive one order; update the reference book and push any predicted match.
  task automatic send_order(input logic side, input logic [7:0] p, input logic [7:0] q,
                            output bit ok);
    logic [7:0] mq;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (order_ready === 1'b1) begin
        order_valid = 1'b1; order_side = side; order_price = p; order_qty = q;
        @(posedge clk);
        ok = 1;
        #1 order_valid = 1'b0;
      end
    end
    if (ok && q != 0) begin
      if (side) begin m_bid_v = 1; m_bid_p = p; m_bid_q = q; end
      else      begin m_ask_v = 1; m_ask_p = p; m_ask_q = q; end
      if (m_bid_v && m_ask_v && m_bid_p >= m_ask_p) begin
        mq = (m_bid_q < m_ask_q) ? m_bid_q : m_ask_q;
        sb.push_back('{bp: m_bid_p, sp: m_ask_p, q: mq});
        m_bid_q = m_bid_q - mq; m_ask_q = m_ask_q - mq;
        if (m_bid_q == 0) m_bid_v = 0;
        if (m_ask_q == 0) m_ask_v = 0;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (match_valid === 1'b1) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit ok;
    exp_t e;
    do_reset();
    n_checks++;
    if ({order_ready, match_valid, match_signal, bid_valid, ask_valid} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 10000",
        {order_ready, match_valid, match_signal, bid_valid, ask_valid});
    end
    send_order(1'b1, 8'd80, 8'd5, ok);
    send_order(1'b0, 8'd70, 8'd5, ok);
    wait_valid(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_setup: match_valid got 0 expected 1"); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    e = {buy_price, sell_price, match_qty};
    if ({order_ready, match_valid, match_signal, bid_valid, ask_valid} !== 5'b0 || e !== '0) begin
      n_fail++; $display("FAIL reset_async: ctl got %b data got %h expected all 0",
        {order_ready, match_valid, match_signal, bid_valid, ask_valid}, e);
    end
`ifdef TRADE_COUNT_EN
    n_checks++;
    if (trade_count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", trade_count);
    end
`endif
    model_clear();
    @(negedge clk);
    match_ready = 1'b1;
    reset_n = 1'b1;
    pulse_cnt = 0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (pulse_cnt != 0 || match_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_drop: pulses got %0d valid %b expected 0 and 0",
        pulse_cnt, match_valid);
    end
  endtask

  task automatic test_no_cross();
    bit ok, seen;
    do_reset();
    match_ready = 1'b1;
    send_order(1'b1, 8'd50, 8'd10, ok);
    send_order(1'b0, 8'd60, 8'd5, ok);
    seen = 0;
    repeat (6) begin @(negedge clk); if (match_valid === 1'b1) seen = 1; end
    n_checks++;
    if (seen || sb.size() != 0) begin
      n_fail++; $display("FAIL no_cross_valid: got %b expected 0 (model pending %0d)", seen, sb.size());
    end
    n_checks++;
    if ({bid_valid, ask_valid} !== 2'b11) begin
      n_fail++; $display("FAIL no_cross_slots: got %b expected 11", {bid_valid, ask_valid});
    end
  endtask

  task automatic test_partial_fill();
    bit ok;
    exp_t e;
    do_reset();
    match_ready = 1'b1;
    send_order(1'b1, 8'd60, 8'd10, ok);
    send_order(1'b0, 8'd55, 8'd4, ok);
    n_checks++;
    if (match_valid !== 1'b0) begin
      n_fail++; $display("FAIL partial_check_cycle: match_valid got %b expected 0", match_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (match_valid !== 1'b1 || match_signal !== 1'b1) begin
      n_fail++; $display("FAIL partial_latency: valid %b signal %b expected 1 1", match_valid, match_signal);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL partial_sb: got empty scoreboard expected one match");
    end else begin
      e = sb.pop_front();
      if ({buy_price, sell_price, match_qty} !== e) begin
        n_fail++; $display("FAIL partial_data: got %0d/%0d/%0d expected %0d/%0d/%0d",
          buy_price, sell_price, match_qty, e.bp, e.sp, e.q);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({match_valid, match_signal, bid_valid, ask_valid} !== 4'b0010) begin
      n_fail++; $display("FAIL partial_after: got %b expected 0010",
        {match_valid, match_signal, bid_valid, ask_valid});
    end
    // Remaining bid 60x6 is consumed exactly by a 60x6 sell.
    send_order(1'b0, 8'd60, 8'd6, ok);
    wait_valid(ok);
    n_checks++;
    if (!ok || sb.size() == 0) begin
      n_fail++; $display("FAIL remain_valid: got valid %b sb %0d expected 1 1", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if ({buy_price, sell_price, match_qty} !== e) begin
        n_fail++; $display("FAIL remain_data: got %0d/%0d/%0d expected %0d/%0d/%0d",
          buy_price, sell_price, match_qty, e.bp, e.sp, e.q);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bid_valid, ask_valid} !== 2'b00) begin
      n_fail++; $display("FAIL remain_slots: got %b expected 00", {bid_valid, ask_valid});
    end
  endtask

  task automatic test_equal();
    bit ok;
    exp_t e;
    do_reset();
    match_ready = 1'b1;
    send_order(1'b0, 8'd40, 8'd7, ok);
    send_order(1'b1, 8'd40, 8'd7, ok);
    wait_valid(ok);
    n_checks++;
    if (!ok || sb.size() == 0) begin
      n_fail++; $display("FAIL equal_valid: got valid %b sb %0d expected 1 1", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if ({buy_price, sell_price, match_qty} !== e) begin
        n_fail++; $display("FAIL equal_data: got %0d/%0d/%0d expected %0d/%0d/%0d",
          buy_price, sell_price, match_qty, e.bp, e.sp, e.q);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({match_valid, bid_valid, ask_valid} !== 3'b000) begin
      n_fail++; $display("FAIL equal_empty: got %b expected 000", {match_valid, bid_valid, ask_valid});
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_t e;
    int bad;
    int p0;
    do_reset();
    match_ready = 1'b0;
    send_order(1'b1, 8'd70, 8'd3, ok);
    send_order(1'b0, 8'd65, 8'd5, ok);
    wait_valid(ok);
    e = (sb.size() != 0) ? sb[0] : '0;
    p0 = pulse_cnt;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (match_valid !== 1'b1 || order_ready !== 1'b0 || match_signal !== 1'b0 ||
          {buy_price, sell_price, match_qty} !== e) bad++;
    end
    n_checks++;
    if (!ok || bad != 0) begin
      n_fail++; $display("FAIL bp_stall: got %0d bad cycles (valid seen %b) expected 0", bad, ok);
    end
    match_ready = 1'b1;
    #1;
    n_checks++;
    if (match_signal !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: match_signal got %b expected 1", match_signal);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    n_checks++;
    if (pulse_cnt - p0 != 1 || match_signal !== 1'b0 || match_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_one_pulse: pulses %0d signal %b valid %b expected 1 0 0",
        pulse_cnt - p0, match_signal, match_valid);
    end
    n_checks++;
    if ({bid_valid, ask_valid} !== {m_bid_v, m_ask_v}) begin
      n_fail++; $display("FAIL bp_slots: got %b expected %b", {bid_valid, ask_valid}, {m_bid_v, m_ask_v});
    end
  endtask

  task automatic test_qty_zero();
    bit ok, seen;
    do_reset();
    match_ready = 1'b1;
    send_order(1'b1, 8'd30, 8'd5, ok);
    send_order(1'b1, 8'd90, 8'd0, ok);
    n_checks++;
    if (!ok || order_ready !== 1'b1) begin
      n_fail++; $display("FAIL qty0_accept: accepted %b ready after %b expected 1 1", ok, order_ready);
    end
    send_order(1'b0, 8'd50, 8'd2, ok);
    seen = 0;
    repeat (6) begin @(negedge clk); if (match_valid === 1'b1) seen = 1; end
    n_checks++;
    if (seen || sb.size() != 0) begin
      n_fail++; $display("FAIL qty0_no_match: got %b expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_t e;
    int exp_cnt;
    do_reset();
    match_ready = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_order(1'b1, 8'd100 + 8'(i), 8'd1 + 8'(i), ok);
      send_order(1'b0, 8'd90, 8'd1 + 8'(i), ok);
      wait_valid(ok);
      n_checks++;
      if (!ok || sb.size() == 0) begin
        n_fail++; $display("FAIL b2b_valid[%0d]: got valid %b sb %0d expected 1 1", i, ok, sb.size());
      end else begin
        e = sb.pop_front();
        if ({buy_price, sell_price, match_qty} !== e) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
            i, buy_price, sell_price, match_qty, e.bp, e.sp, e.q);
        end
      end
      @(posedge clk); #1;
      if (exp_cnt < 3) exp_cnt++;
`ifdef TRADE_COUNT_EN
      n_checks++;
      if (int'(trade_count) != exp_cnt) begin
        n_fail++; $display("FAIL trade_count[%0d]: got %0d expected %0d", i, trade_count, exp_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_no_cross();
    test_partial_fill();
    test_equal();
    test_backpressure();
    test_qty_zero();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
